game_flow_ctrl: RTL

Top-level game sequencer for the FPGA arcade game. Owns the title / play / hit-recovery / game-over flow, gates collision events into the `lives` counter, and resets it. It also issues player respawn pulses, tracks the level number, and freezes movement during hit recovery. It sits between the collision/goal detectors and the `lives` block, and its outputs drive the player-movement and VGA overlay logic.

---
 rtl/game_pkg.sv | 19 +
 rtl/game_flow_ctrl_if.sv | 27 ++
 rtl/rise_detect.sv | 19 +
 rtl/game_flow_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and widths for the game flow blocks
package game_pkg;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_HIT     = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl,
                                                   input int max_level);
    return (int'(lvl) >= max_level) ? lvl : lvl + 1'b1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - detector/lives/overlay signal bundle around the game sequencer
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic               i_Start;
  logic               i_Collision;
  logic               i_Goal;
  logic [LIVES_W-1:0] i_Lives;
  logic               o_Lives_Reset;
  logic               o_Hit;
  logic               o_Respawn;
  logic               o_Run;
  logic               o_Blink;
  logic [LEVEL_W-1:0] o_Level;
  logic [1:0]         o_State;

  modport master (
    output i_Start, i_Collision, i_Goal, i_Lives,
    input  o_Lives_Reset, o_Hit, o_Respawn, o_Run, o_Blink, o_Level, o_State
  );

  modport slave (
    input  i_Start, i_Collision, i_Goal, i_Lives,
    output o_Lives_Reset, o_Hit, o_Respawn, o_Run, o_Blink, o_Level, o_State
  );

endinterface

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-bit rising-edge detector with synchronous reset
module rise_detect (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_In,
  output logic o_Rise
);

  logic r_prev;

  // Prev clears on reset so an input held high through release reads as an edge.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_prev <= 1'b0;
    else         r_prev <= i_In;
  end

  assign o_Rise = i_In & ~r_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - title/play/hit/game-over sequencer driving lives, respawn and level
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int RESPAWN_CLKS  = 25_000_000,
  parameter int BLINK_CLKS    = 3_125_000,
  parameter int GAMEOVER_CLKS = 50_000_000,
  parameter int MAX_LEVEL     = 7
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  game_flow_ctrl_if.slave  bus
);

  localparam int MAX_T = (RESPAWN_CLKS > GAMEOVER_CLKS) ? RESPAWN_CLKS : GAMEOVER_CLKS;
  localparam int TMR_W = $clog2(MAX_T + 1);
  localparam int BLK_W = $clog2(BLINK_CLKS + 1);
  localparam logic [TMR_W-1:0] HIT_LOAD  = TMR_W'(RESPAWN_CLKS - 1);
  localparam logic [TMR_W-1:0] OVER_LOAD = TMR_W'(GAMEOVER_CLKS);
  localparam logic [BLK_W-1:0] BLK_LOAD  = BLK_W'(BLINK_CLKS - 1);

  logic w_start_rise, w_coll_rise, w_goal_rise;

  rise_detect u_start (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_In(bus.i_Start),     .o_Rise(w_start_rise));
  rise_detect u_coll  (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_In(bus.i_Collision), .o_Rise(w_coll_rise));
  rise_detect u_goal  (.i_Clk(i_Clk), .i_Reset(i_Reset), .i_In(bus.i_Goal),      .o_Rise(w_goal_rise));

  state_t             r_state, w_state;
  logic [TMR_W-1:0]   r_timer, w_timer;
  logic [BLK_W-1:0]   r_blink_cnt, w_blink_cnt;
  logic               r_blink, w_blink;
  logic [LEVEL_W-1:0] r_level, w_level;
  logic               r_lives_reset, w_lives_reset;
  logic               r_hit, w_hit;
  logic               r_respawn, w_respawn;
  logic               r_run, w_run;

  always_comb begin
    w_state       = r_state;
    w_timer       = r_timer;
    w_blink_cnt   = r_blink_cnt;
    w_blink       = 1'b0;
    w_level       = r_level;
    w_lives_reset = 1'b0;
    w_hit         = 1'b0;
    w_respawn     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state       = ST_PLAYING;
          w_lives_reset = 1'b1;
          w_respawn     = 1'b1;
          w_level       = '0;
        end
      end
      ST_PLAYING: begin
        if (w_coll_rise) begin
          w_state     = ST_HIT;
          w_hit       = 1'b1;
          w_timer     = HIT_LOAD;
          w_blink_cnt = BLK_LOAD;
          w_blink     = 1'b1;
        end else if (w_goal_rise) begin
          w_level   = level_inc(r_level, MAX_LEVEL);
          w_respawn = 1'b1;
        end
      end
      ST_HIT: begin
        if (r_timer == '0) begin
          if (bus.i_Lives == '0) begin
            w_state = ST_OVER;
            w_timer = OVER_LOAD;
          end else begin
            w_state   = ST_PLAYING;
            w_respawn = 1'b1;
          end
        end else begin
          w_timer = r_timer - 1'b1;
          if (r_blink_cnt == '0) begin
            w_blink     = ~r_blink;
            w_blink_cnt = BLK_LOAD;
          end else begin
            w_blink     = r_blink;
            w_blink_cnt = r_blink_cnt - 1'b1;
          end
        end
      end
      ST_OVER: begin
        // Timer parks at zero once the holdoff has elapsed; only then is Start honoured.
        if (r_timer != '0) begin
          w_timer = r_timer - 1'b1;
        end else if (w_start_rise) begin
          w_state       = ST_PLAYING;
          w_lives_reset = 1'b1;
          w_respawn     = 1'b1;
          w_level       = '0;
        end
      end
      default: w_state = ST_IDLE;
    endcase

    w_run = (w_state == ST_PLAYING);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_blink_cnt   <= '0;
      r_blink       <= 1'b0;
      r_level       <= '0;
      r_lives_reset <= 1'b0;
      r_hit         <= 1'b0;
      r_respawn     <= 1'b0;
      r_run         <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_timer       <= w_timer;
      r_blink_cnt   <= w_blink_cnt;
      r_blink       <= w_blink;
      r_level       <= w_level;
      r_lives_reset <= w_lives_reset;
      r_hit         <= w_hit;
      r_respawn     <= w_respawn;
      r_run         <= w_run;
    end
  end

  assign bus.o_State       = r_state;
  assign bus.o_Level       = r_level;
  assign bus.o_Lives_Reset = r_lives_reset;
  assign bus.o_Hit         = r_hit;
  assign bus.o_Respawn     = r_respawn;
  assign bus.o_Run         = r_run;
  assign bus.o_Blink       = r_blink;

endmodule
